sd_ch_sched: RTL and testbench

Multi-channel result scheduler for the sigma-delta filter module. It sits between N channel instances and the shared bus/FIFO port. It latches each channel's filter-data-update pulse and 32-bit result, then serializes the pending results to one output using round-robin arbitration and a valid/ready handshake. It also flags per-channel overruns, where a new result arrives before the previous one was forwarded.

---
 rtl/sd_sched_pkg.sv | 15 +
 rtl/sd_rr_arb.sv | 36 +++
 rtl/sd_ch_sched.sv | 143 ++++++++++++++
 tb/tb_sd_ch_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_sched_pkg.sv
// Shared types and helpers for the sigma-delta multi-channel result scheduler.
package sd_sched_pkg;

    // Output-side scheduler state: idle, or presenting a result to the consumer
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Width of a channel index / round-robin pointer for a given channel count
    function automatic int ptr_width(input int nch);
        return (nch < 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/sd_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// ptr, wrapping around, using a masked lower copy and an unmasked upper copy.
module sd_rr_arb #(
    parameter int NCH  = 4,
    parameter int PTRW = 2
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [PTRW-1:0] ptr_i,
    output logic [PTRW-1:0] gnt_idx_o,
    output logic            any_o
);

    logic [NCH-1:0]   mask;
    logic [2*NCH-1:0] dbl;
    logic             found;

    // Lowest set bit of {req, req & above-ptr mask} is the next channel in rotation
    always_comb begin
        mask      = '0;
        dbl       = '0;
        found     = 1'b0;
        gnt_idx_o = '0;
        any_o     = |req_i;
        for (int i = 0; i < NCH; i++) begin
            mask[i] = (PTRW'(i) > ptr_i);
        end
        dbl = {req_i, req_i & mask};
        for (int k = 0; k < 2 * NCH; k++) begin
            if (!found && dbl[k]) begin
                found     = 1'b1;
                gnt_idx_o = PTRW'(k % NCH);
            end
        end
    end

endmodule

// File: rtl/sd_ch_sched.sv
// Multi-channel result scheduler: latches per-channel filter results, flags
// overruns, and forwards pending results one at a time over a valid/ready port.
module sd_ch_sched
    import sd_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 32
) (
    input  logic                    SYSCLK,
    input  logic                    SYSRST,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH-1:0]          ch_update,
    input  logic [NCH*DW-1:0]       ch_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic [NCH-1:0]          ovr_flag,
    input  logic [NCH-1:0]          ovr_clr
);

    localparam int PTRW = ptr_width(NCH);

    state_e          state_q, state_d;
    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  ovr_q, ovr_d;
    logic [DW-1:0]   hold_q [NCH];
    logic [DW-1:0]   hold_d [NCH];
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [PTRW-1:0] out_ch_q, out_ch_d;

    logic [PTRW-1:0] gnt_idx;
    logic            any_req;
    logic            grant;
    logic [NCH-1:0]  upd;
    logic [NCH-1:0]  taken;

    sd_rr_arb #(
        .NCH  (NCH),
        .PTRW (PTRW)
    ) u_arb (
        .req_i     (pend_q),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    // Output FSM: grant when the output register is free or being accepted this cycle
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        grant       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant = 1'b1;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (any_req) begin
                        grant = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (grant) begin
            out_data_d  = hold_q[gnt_idx];
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = gnt_idx;
            state_d     = S_SEND;
        end
    end

    // Per-channel hold/pending/overrun next state; a new update beats a same-cycle grant
    always_comb begin
        upd    = '0;
        taken  = '0;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        hold_d = hold_q;
        for (int i = 0; i < NCH; i++) begin
            upd[i]   = ch_update[i] && ch_en[i];
            taken[i] = grant && (gnt_idx == PTRW'(i));
            if (upd[i]) begin
                hold_d[i] = ch_data[i*DW +: DW];
            end
            if (!ch_en[i]) begin
                pend_d[i] = 1'b0;
            end else if (upd[i]) begin
                pend_d[i] = 1'b1;
            end else if (taken[i]) begin
                pend_d[i] = 1'b0;
            end
            ovr_d[i] = (upd[i] && pend_q[i] && !taken[i]) || (ovr_q[i] && !ovr_clr[i]);
        end
    end

    // State registers with synchronous reset; ptr starts at the last channel so channel 0 wins first
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            ovr_q       <= '0;
            ptr_q       <= PTRW'(NCH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign ovr_flag  = ovr_q;

endmodule

// File: tb/tb_sd_ch_sched.sv
// Testbench for sd_ch_sched: a transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_sd_ch_sched;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic              SYSCLK;
    logic              SYSRST;
    logic [NCH-1:0]    chEn;
    logic [NCH-1:0]    chUpdate;
    logic [NCH*DW-1:0] chData;
    logic              outValid;
    logic              outReady;
    logic [DW-1:0]     outData;
    logic [1:0]        outCh;
    logic [NCH-1:0]    ovrFlag;
    logic [NCH-1:0]    ovrClr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit             modelStarted = 1'b0;
    bit             mPend [NCH];
    logic [DW-1:0]  mHold [NCH];
    logic [NCH-1:0] mOvr;
    int             mPtr;
    bit             mValid;
    logic [DW-1:0]  mData;
    int             mCh;
    int             mGrant;

    // Log of accepted transfers seen on the output port
    int             accCh   [$];
    logic [DW-1:0]  accData [$];
    int             accCyc  [$];
    int             cycleCount = 0;

    sd_ch_sched #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .SYSCLK    (SYSCLK),
        .SYSRST    (SYSRST),
        .ch_en     (chEn),
        .ch_update (chUpdate),
        .ch_data   (chData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_ch    (outCh),
        .ovr_flag  (ovrFlag),
        .ovr_clr   (ovrClr)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NCH-1:0] en, input logic [NCH-1:0] upd,
                                 input logic [NCH*DW-1:0] data, input logic ready, input logic [NCH-1:0] clr);
        @(posedge SYSCLK);
        #2;
        SYSRST   = rst;
        chEn     = en;
        chUpdate = upd;
        chData   = data;
        outReady = ready;
        ovrClr   = clr;
    endtask

    function automatic logic [NCH*DW-1:0] packData(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                   input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic doReset();
        applyStimulus(1'b1, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        accCh.delete();
        accData.delete();
        accCyc.delete();
    endtask

    task automatic waitAccepts(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (accCh.size() < target && n < budget) begin
            @(negedge SYSCLK);
            n++;
        end
        checkOutput(name, accCh.size(), target);
    endtask

    // Reference model: one step per rising edge, from the rules for grant, pending and overrun
    always @(posedge SYSCLK) begin
        if (SYSRST) begin
            modelStarted = 1'b1;
            mValid = 1'b0;
            mData  = '0;
            mCh    = 0;
            mOvr   = '0;
            mPtr   = NCH - 1;
            for (int i = 0; i < NCH; i++) begin
                mPend[i] = 1'b0;
                mHold[i] = '0;
            end
        end else if (modelStarted) begin
            mGrant = -1;
            if (!mValid || outReady) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (mGrant < 0 && mPend[(mPtr + k) % NCH]) mGrant = (mPtr + k) % NCH;
                end
                if (mGrant >= 0) begin
                    mValid = 1'b1;
                    mData  = mHold[mGrant];
                    mCh    = mGrant;
                    mPtr   = mGrant;
                end else begin
                    mValid = 1'b0;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (chUpdate[i] && chEn[i] && mPend[i] && mGrant != i) mOvr[i] = 1'b1;
                else if (ovrClr[i]) mOvr[i] = 1'b0;
                if (!chEn[i]) begin
                    mPend[i] = 1'b0;
                end else if (chUpdate[i]) begin
                    mPend[i] = 1'b1;
                    mHold[i] = chData[i*DW +: DW];
                end else if (mGrant == i) begin
                    mPend[i] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, and logging of accepted transfers
    always @(negedge SYSCLK) begin
        cycleCount++;
        if (modelStarted) begin
            checkOutput("cmp_valid", outValid, mValid);
            if (mValid) begin
                checkOutput("cmp_data", outData, mData);
                checkOutput("cmp_ch", outCh, mCh);
            end
            checkOutput("cmp_ovr", ovrFlag, mOvr);
            if (outValid && outReady && !SYSRST) begin
                accCh.push_back(int'(outCh));
                accData.push_back(outData);
                accCyc.push_back(cycleCount);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        SYSRST   = 1'b1;
        chEn     = 4'hF;
        chUpdate = 4'h0;
        chData   = '0;
        outReady = 1'b0;
        ovrClr   = 4'h0;

        // Reset values
        doReset();
        @(negedge SYSCLK);
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_data", outData, 0);
        checkOutput("reset_ch", outCh, 0);
        checkOutput("reset_ovr", ovrFlag, 0);

        // Single result on channel 1
        applyStimulus(1'b0, 4'hF, 4'b0010, packData(0, 32'hDEAD_BEEF, 0, 0), 1'b1, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        @(negedge SYSCLK);
        checkOutput("single_pend_only", outValid, 0);
        @(negedge SYSCLK);
        checkOutput("single_valid", outValid, 1);
        checkOutput("single_ch", outCh, 1);
        checkOutput("single_data", outData, 32'hDEAD_BEEF);
        @(negedge SYSCLK);
        checkOutput("single_valid_drop", outValid, 0);

        // Round-robin: two rounds of all four channels
        doReset();
        applyStimulus(1'b0, 4'hF, 4'hF, packData(32'h10, 32'h11, 32'h12, 32'h13), 1'b1, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        waitAccepts(4, 20, "rr1_count");
        if (accCh.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("rr1_ch%0d", i), accCh[i], i);
                checkOutput($sformatf("rr1_data%0d", i), accData[i], 32'h10 + i);
                checkOutput($sformatf("rr1_b2b%0d", i), accCyc[i] - accCyc[0], i);
            end
        end
        applyStimulus(1'b0, 4'hF, 4'hF, packData(32'h20, 32'h21, 32'h22, 32'h23), 1'b1, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        waitAccepts(8, 20, "rr2_count");
        if (accCh.size() >= 8) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("rr2_ch%0d", i), accCh[4 + i], i);
                checkOutput($sformatf("rr2_data%0d", i), accData[4 + i], 32'h20 + i);
            end
        end

        // Backpressure: channel 2 result held for five stalled cycles
        doReset();
        applyStimulus(1'b0, 4'hF, 4'b0100, packData(0, 0, 32'hA5, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        @(negedge SYSCLK);
        checkOutput("bp_not_yet", outValid, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge SYSCLK);
            checkOutput($sformatf("bp_valid%0d", i), outValid, 1);
            checkOutput($sformatf("bp_data%0d", i), outData, 32'hA5);
            checkOutput($sformatf("bp_ch%0d", i), outCh, 2);
        end
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        @(negedge SYSCLK);
        @(negedge SYSCLK);
        checkOutput("bp_first_ready_accept", outValid, 0);
        checkOutput("bp_count", accCh.size(), 1);

        // Overrun on channel 1 while channel 0 occupies the output
        doReset();
        applyStimulus(1'b0, 4'hF, 4'b0001, packData(32'h100, 0, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'b0010, packData(0, 32'h1, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'b0010, packData(0, 32'h2, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        @(negedge SYSCLK);
        checkOutput("ovr_set", ovrFlag, 4'b0010);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        waitAccepts(2, 10, "ovr_count");
        if (accCh.size() >= 2) begin
            checkOutput("ovr_first_ch", accCh[0], 0);
            checkOutput("ovr_first_data", accData[0], 32'h100);
            checkOutput("ovr_newest_ch", accCh[1], 1);
            checkOutput("ovr_newest_data", accData[1], 32'h2);
        end
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'b0010);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        @(negedge SYSCLK);
        checkOutput("ovr_cleared", ovrFlag, 4'b0000);
        applyStimulus(1'b0, 4'hF, 4'b0001, packData(32'h55, 0, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'b0010, packData(0, 32'h3, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'b0010, packData(0, 32'h4, 0, 0), 1'b0, 4'b0010);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        @(negedge SYSCLK);
        checkOutput("ovr_set_beats_clr", ovrFlag, 4'b0010);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'b0010);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        waitAccepts(4, 10, "ovr2_count");
        if (accCh.size() >= 4) begin
            checkOutput("ovr2_data", accData[3], 32'h4);
        end

        // Disable drops a pending channel; disabled updates are ignored
        doReset();
        applyStimulus(1'b0, 4'hF, 4'b0001, packData(32'h7, 0, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'b1000, packData(0, 0, 0, 32'h9), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b0111, 4'h0, '0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        repeat (6) @(negedge SYSCLK);
        checkOutput("en3_count", accCh.size(), 1);
        if (accCh.size() >= 1) checkOutput("en3_only_ch0", accCh[0], 0);
        applyStimulus(1'b0, 4'b1110, 4'b0001, packData(32'h77, 0, 0, 0), 1'b1, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        repeat (5) @(negedge SYSCLK);
        checkOutput("en0_valid", outValid, 0);
        checkOutput("en0_count", accCh.size(), 1);

        // Reset mid-transfer drops in-flight and pending results
        applyStimulus(1'b0, 4'hF, 4'b0100, packData(0, 0, 32'h33, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'b0010, packData(0, 32'h44, 0, 0), 1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b0, 4'h0);
        @(negedge SYSCLK);
        checkOutput("rst_pre_valid", outValid, 1);
        applyStimulus(1'b1, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        accCh.delete();
        accData.delete();
        accCyc.delete();
        applyStimulus(1'b0, 4'hF, 4'b1001, packData(32'h50, 0, 0, 32'h53), 1'b1, 4'h0);
        @(negedge SYSCLK);
        checkOutput("rst_post_valid", outValid, 0);
        checkOutput("rst_post_data", outData, 0);
        checkOutput("rst_post_ch", outCh, 0);
        applyStimulus(1'b0, 4'hF, 4'h0, '0, 1'b1, 4'h0);
        waitAccepts(2, 10, "rst_count");
        repeat (4) @(negedge SYSCLK);
        checkOutput("rst_no_stale", accCh.size(), 2);
        if (accCh.size() >= 2) begin
            checkOutput("rst_first_ch", accCh[0], 0);
            checkOutput("rst_first_data", accData[0], 32'h50);
            checkOutput("rst_second_ch", accCh[1], 3);
            checkOutput("rst_second_data", accData[1], 32'h53);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
